// File: rtl/rampa_pwm_motores_pkg.sv
// Shared types and constants for the soft-start / soft-stop motor PWM block.
// Optional feature macro: RAMPA_PARADA_EN (emergency stop input).
package rampa_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam int N_CH = 3;
    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    // Full-scale duty for a given counter width.
    function automatic int pwm_max_of(input int bits);
        return (1 << bits) - 1;
    endfunction

    localparam int PWM_BITS_DEF = 8;
    localparam int PWM_MAX_DEF  = pwm_max_of(PWM_BITS_DEF);

endpackage

// File: rtl/rampa_pwm_motores_if.sv
// Motor command / PWM drive bundle between the motor controller and the ramp stage.
interface rampa_pwm_motores_if;

    logic [2:0] motor_en;   // bit0=R, bit1=G, bit2=B run commands
    logic [2:0] pwm_out;    // PWM drive per channel
    logic [2:0] at_speed;   // channel at full duty
    logic       busy;       // any channel not OFF

    modport master (output motor_en, input pwm_out, input at_speed, input busy);
    modport slave  (input motor_en, output pwm_out, output at_speed, output busy);

endinterface

// File: rtl/rampa_pwm_motores_canal.sv
// One ramp channel: run/stop FSM, duty ramp, period-aligned shadow duty and PWM compare.
// Optional feature macro: RAMPA_PARADA_EN (adds the synchronized stop input).
module canal_rampa
    import rampa_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int RAMP_STEP = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                step_tick,
`ifdef RAMPA_PARADA_EN
    input  logic                parada,
`endif
    input  logic                motor_en,
    output logic                pwm_out,
    output logic                at_speed,
    output logic                busy
);

    localparam logic [1:0] S_OFF  = OFF;
    localparam logic [1:0] S_UP   = RAMP_UP;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DOWN = RAMP_DOWN;

    localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(pwm_max_of(PWM_BITS));
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(pwm_max_of(PWM_BITS) - 1);
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(RAMP_STEP);

    logic [1:0]          state, state_nx;
    logic [PWM_BITS-1:0] duty, duty_nx, duty_sh;
    logic [PWM_BITS:0]   sum;
    logic                stop;

`ifdef RAMPA_PARADA_EN
    assign stop = parada;
`else
    assign stop = 1'b0;
`endif

    // Next state and duty: a run/stop change wins over a same-cycle ramp step.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_nx = state;
        duty_nx  = duty;
        sum      = {1'b0, duty} + {1'b0, STEP};
        case (state)
            S_OFF: begin
                duty_nx = '0;
                if (motor_en) state_nx = S_UP;
            end
            S_UP: begin
                if (!motor_en) begin
                    state_nx = S_DOWN;
                end else if (step_tick) begin
                    if (sum >= {1'b0, DUTY_MAX}) begin
                        duty_nx  = DUTY_MAX;
                        state_nx = S_RUN;
                    end else begin
                        duty_nx = sum[PWM_BITS-1:0];
                    end
                end
            end
            S_RUN: begin
                duty_nx = DUTY_MAX;
                if (!motor_en) state_nx = S_DOWN;
            end
            default: begin
                if (motor_en) begin
                    state_nx = S_UP;
                end else if (step_tick) begin
                    if (duty <= STEP) begin
                        duty_nx  = '0;
                        state_nx = S_OFF;
                    end else begin
                        duty_nx = duty - STEP;
                    end
                end
            end
        endcase
        if (stop) begin
            state_nx = S_OFF;
            duty_nx  = '0;
        end
    end

    // State, duty, period-aligned shadow duty and registered PWM/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_OFF;
            duty     <= '0;
            duty_sh  <= '0;
            pwm_out  <= 1'b0;
            at_speed <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nx;
            duty  <= duty_nx;
            if (stop)
                duty_sh <= '0;
            else if (cnt == CNT_LAST)
                duty_sh <= duty;
            pwm_out  <= !stop && (cnt < duty_sh);
            at_speed <= (state_nx == S_RUN);
            busy     <= (state_nx != S_OFF);
        end
    end

endmodule

// File: rtl/rampa_pwm_motores.sv
// Soft-start / soft-stop PWM drive for the R, G and B dosing motors.
// Three ramp channels share one free-running PWM counter and one ramp-step prescaler.
// Optional feature macro: RAMPA_PARADA_EN (emergency stop input 'parada').
module rampa_pwm_motores
    import rampa_pkg::*;
#(
    parameter int PWM_BITS       = PWM_BITS_DEF,
    parameter int RAMP_STEP      = 8,
    parameter int TICKS_PER_STEP = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef RAMPA_PARADA_EN
    input  logic                  parada,
`endif
    rampa_pwm_motores_if.slave    bus
);

    localparam logic [PWM_BITS-1:0] CNT_LAST   = PWM_BITS'(pwm_max_of(PWM_BITS) - 1);
    localparam int                  PRESC_W    = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICKS_PER_STEP - 1);

    logic [PWM_BITS-1:0] cnt;
    logic [PRESC_W-1:0]  presc;
    logic                step_tick;
    logic [N_CH-1:0]     pwm_v, at_v, busy_v;

    assign step_tick = (presc == PRESC_LAST);

    // Free-running PWM counter, period PWM_MAX clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               cnt <= '0;
        else if (cnt == CNT_LAST) cnt <= '0;
        else                      cnt <= cnt + 1'b1;
    end

    // Ramp-step prescaler; step_tick marks its wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         presc <= '0;
        else if (step_tick) presc <= '0;
        else                presc <= presc + 1'b1;
    end

`ifdef RAMPA_PARADA_EN
    logic parada_m, parada_s;

    // Two-flop synchronizer for the asynchronous stop request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parada_m <= 1'b0;
            parada_s <= 1'b0;
        end else begin
            parada_m <= parada;
            parada_s <= parada_m;
        end
    end
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_canal
        canal_rampa #(
            .PWM_BITS  (PWM_BITS),
            .RAMP_STEP (RAMP_STEP)
        ) u_canal (
            .clk       (clk),
            .reset     (reset),
            .cnt       (cnt),
            .step_tick (step_tick),
`ifdef RAMPA_PARADA_EN
            .parada    (parada_s),
`endif
            .motor_en  (bus.motor_en[i]),
            .pwm_out   (pwm_v[i]),
            .at_speed  (at_v[i]),
            .busy      (busy_v[i])
        );
    end

    assign bus.pwm_out  = pwm_v;
    assign bus.at_speed = at_v;
    assign bus.busy     = |busy_v;

endmodule

// File: tb/tb_rampa_pwm_motores.sv
// Bench for rampa_pwm_motores: two instances (RAMP_STEP 5 and 4), PWM_BITS=4, TICKS_PER_STEP=30.
// Expected duty levels are queued per channel when commands are driven; a monitor
// measures high cycles in each aligned PWM period and pops/compares on every change.
module tb_rampa_pwm_motores;

    localparam int PWM_BITS = 4;
    localparam int PWM_MAX  = 15;
    localparam int TICKS    = 30;

    logic clk = 1'b0;
    logic reset;
`ifdef RAMPA_PARADA_EN
    logic parada = 1'b0;
`endif

    rampa_pwm_motores_if bus_a ();
    rampa_pwm_motores_if bus_b ();

    rampa_pwm_motores #(.PWM_BITS(PWM_BITS), .RAMP_STEP(5), .TICKS_PER_STEP(TICKS)) dut_a (
        .clk   (clk),
        .reset (reset),
`ifdef RAMPA_PARADA_EN
        .parada(parada),
`endif
        .bus   (bus_a)
    );

    rampa_pwm_motores #(.PWM_BITS(PWM_BITS), .RAMP_STEP(4), .TICKS_PER_STEP(TICKS)) dut_b (
        .clk   (clk),
        .reset (reset),
`ifdef RAMPA_PARADA_EN
        .parada(parada),
`endif
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_q[6][$];
    int hi[6];
    int last[6];
    int ncyc;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Edges since the last reset release; PWM counter and prescaler phase follow from it.
    always @(posedge clk or negedge reset) begin
        if (!reset) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    // Period monitor: samples after edges 15m+1..15m+15 reflect one shadow duty.
    always @(negedge clk) begin
        logic [5:0] pw;
        int m;
        pw = {bus_b.pwm_out, bus_a.pwm_out};
        if (!reset) begin
            for (int c = 0; c < 6; c++) begin
                hi[c]   <= 0;
                last[c] <= 0;
            end
        end else if (ncyc > 0) begin
            for (int c = 0; c < 6; c++) begin
                m = hi[c] + int'(pw[c]);
                if ((ncyc - 1) % PWM_MAX == PWM_MAX - 1) begin
                    hi[c] <= 0;
                    if (m != last[c]) begin
                        if (exp_q[c].size() == 0)
                            check($sformatf("duty_ch%0d_unexpected", c), m, last[c]);
                        else
                            check($sformatf("duty_ch%0d", c), m, exp_q[c].pop_front());
                    end
                    last[c] <= m;
                end else begin
                    hi[c] <= m;
                end
            end
        end
    end

    function automatic int get_sig(input int sel);
        case (sel)
            0:       return int'(bus_a.at_speed);
            1:       return int'(bus_b.at_speed);
            2:       return int'(bus_a.busy);
            default: return int'(bus_b.busy);
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input int want, input int budget);
        int n = 0;
        while (get_sig(sel) != want && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, get_sig(sel), want);
    endtask

    // Return on the negedge right after a step_tick edge.
    task automatic align_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ncyc % TICKS != 0 && n < 2 * TICKS);
        check("align_tick", ncyc % TICKS, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset           = 1'b0;
        bus_a.motor_en  = 3'b111;
        bus_b.motor_en  = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_pwm_out", int'(bus_a.pwm_out), 0);
        check("rst_at_speed", int'(bus_a.at_speed), 0);
        check("rst_busy", int'(bus_a.busy), 0);

        // Release with all commands high: busy follows the first edge.
        #2 reset = 1'b1;
        #1 check("busy_before_edge", int'(bus_a.busy), 0);
        @(posedge clk);
        #1 check("busy_after_edge", int'(bus_a.busy), 1);
        check("at_speed_after_edge", int'(bus_a.at_speed), 0);

        @(negedge clk);
        #2 reset = 1'b0;
        bus_a.motor_en = 3'b000;
        @(negedge clk);
        #2 reset = 1'b1;

        // Ramp up R (step 5) and channel 0 of the step-4 instance together.
        repeat (3) @(negedge clk);
        bus_a.motor_en = 3'b001;
        bus_b.motor_en = 3'b001;
        exp_q[0].push_back(5);  exp_q[0].push_back(10); exp_q[0].push_back(15);
        exp_q[3].push_back(4);  exp_q[3].push_back(8);
        exp_q[3].push_back(12); exp_q[3].push_back(15);
        wait_for("r_at_speed", 0, 3'b001, 300);
        wait_for("b_ch0_at_speed", 1, 3'b001, 300);

        // Saturated channel ramps down without underflow.
        bus_b.motor_en = 3'b000;
        exp_q[3].push_back(11); exp_q[3].push_back(7);
        exp_q[3].push_back(3);  exp_q[3].push_back(0);

        // G: up to 10, released mid-ramp, back down to 0.
        align_tick();
        bus_a.motor_en = 3'b011;
        exp_q[1].push_back(5); exp_q[1].push_back(10);
        exp_q[1].push_back(5); exp_q[1].push_back(0);
        repeat (2 * TICKS + 5) @(negedge clk);
        bus_a.motor_en = 3'b001;
        check("at_speed_g_mid", int'(bus_a.at_speed), 3'b001);
        repeat (70) @(negedge clk);
        check("busy_r_still_run", int'(bus_a.busy), 1);
        wait_for("b_idle", 3, 0, 300);

        // R ramps down while B ramps up concurrently.
        bus_a.motor_en = 3'b100;
        exp_q[0].push_back(10); exp_q[0].push_back(5); exp_q[0].push_back(0);
        exp_q[2].push_back(5);  exp_q[2].push_back(10); exp_q[2].push_back(15);
        wait_for("b_at_speed", 0, 3'b100, 400);
        check("busy_b_run", int'(bus_a.busy), 1);
        repeat (40) @(negedge clk);
        for (int c = 0; c < 6; c++)
            check($sformatf("queue_drained_ch%0d", c), exp_q[c].size(), 0);
        check("b_pwm_const_high", int'(bus_a.pwm_out), 3'b100);

        // Asynchronous reset between edges clears outputs without a clock.
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_rst_pwm_out", int'(bus_a.pwm_out), 0);
        check("async_rst_at_speed", int'(bus_a.at_speed), 0);
        check("async_rst_busy", int'(bus_a.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
